// File: rtl/video_fb.sv
// VGA timing generator with a centred, pixel-doubled framebuffer window.
// Three-stage pipeline: counters -> RAM address -> RAM data -> colour/syncs.
module video_fb #(
  parameter int HA     = 640,
  parameter int HFP    = 16,
  parameter int HS     = 96,
  parameter int HBP    = 48,
  parameter int VA     = 480,
  parameter int VFP    = 11,
  parameter int VS     = 2,
  parameter int VBP    = 31,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int WIN_W  = 256,
  parameter int WIN_H  = 128,
  parameter int BPP    = 1,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        vga_data,
  output logic [ADDR_W-1:0] vga_addr,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [23:0]       border_rgb,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [23:0]       pal_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_irq,
  output logic              vblank
);
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int HB  = (HA - 2*WIN_W) / 2;
  localparam int VB  = (VA - 2*WIN_H) / 2;
  localparam int BPL = WIN_W * BPP / 8;
  localparam int PPB = 8 / BPP;
  localparam int HCW = $clog2(HT);
  localparam int VCW = $clog2(VT);

  logic [HCW-1:0]    hc_q;
  logic [VCW-1:0]    vc_q;
  logic [ADDR_W-1:0] base_q, addr_q, addr_d;
  logic [31:0]       hx, vy, xw, yw;
  logic              win0, de0, hs0, vs0;
  logic [2:0]        x1_q, x2_q;
  logic              win1_q, de1_q, hs1_q, vs1_q;
  logic              win2_q, de2_q, hs2_q, vs2_q;
  logic [23:0]       rgb_q, rgb_d;
  logic              hs3_q, vs3_q, de3_q;
  logic [23:0]       pal_q [16];
  logic [2:0]        k;
  logic [7:0]        sh;
  logic [3:0]        idx;

  assign hx = 32'(hc_q);
  assign vy = 32'(vc_q);

  // Counters; the framebuffer base is captured on the last clock of each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      base_q <= '0;
    end else begin
      if (hx == HT-1) begin
        hc_q <= '0;
        vc_q <= (vy == VT-1) ? '0 : vc_q + 1'b1;
        if (vy == VT-1) base_q <= fb_base;
      end else begin
        hc_q <= hc_q + 1'b1;
      end
    end
  end

  assign frame_irq = (hx == 32'd0) && (vy == VA);
  assign vblank    = (vy >= VA);

  always_comb begin
    de0  = (hx < HA) && (vy < VA);
    win0 = (hx >= HB) && (hx < HB + 2*WIN_W) && (vy >= VB) && (vy < VB + 2*WIN_H);
    hs0  = (hx >= HA+HFP && hx < HA+HFP+HS) ? HS_POL : !HS_POL;
    vs0  = (vy >= VA+VFP && vy < VA+VFP+VS) ? VS_POL : !VS_POL;
    xw   = (hx - 32'(HB)) >> 1;
    yw   = (vy - 32'(VB)) >> 1;
    // Outside the window the address holds so the RAM port stays quiet.
    addr_d = win0 ? base_q + ADDR_W'(yw*32'(BPL) + ((xw*32'(BPP)) >> 3)) : addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      x1_q   <= '0;
      win1_q <= 1'b0;
      de1_q  <= 1'b0;
      hs1_q  <= !HS_POL;
      vs1_q  <= !VS_POL;
      x2_q   <= '0;
      win2_q <= 1'b0;
      de2_q  <= 1'b0;
      hs2_q  <= !HS_POL;
      vs2_q  <= !VS_POL;
      rgb_q  <= '0;
      hs3_q  <= !HS_POL;
      vs3_q  <= !VS_POL;
      de3_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      x1_q   <= xw[2:0];
      win1_q <= win0;
      de1_q  <= de0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      x2_q   <= x1_q;
      win2_q <= win1_q;
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb_q  <= rgb_d;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      de3_q  <= de2_q;
    end
  end

  // Leftmost logical pixel sits in the byte's MSBs.
  always_comb begin
    k     = x2_q & 3'(PPB-1);
    sh    = vga_data << (32'(k) * 32'(BPP));
    idx   = 4'(sh >> (8-BPP));
    rgb_d = '0;
    if (!de2_q)        rgb_d = '0;
    else if (!win2_q)  rgb_d = border_rgb;
    else if (BPP < 8)  rgb_d = pal_q[idx];
    else               rgb_d = {vga_data[7:5], vga_data[7:5], vga_data[7:6],
                                vga_data[4:2], vga_data[4:2], vga_data[4:3],
                                vga_data[1:0], vga_data[1:0], vga_data[1:0], vga_data[1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign vga_addr = addr_q;
  assign vga_r    = rgb_q[23:16];
  assign vga_g    = rgb_q[15:8];
  assign vga_b    = rgb_q[7:0];
  assign vga_hs   = hs3_q;
  assign vga_vs   = vs3_q;
  assign vga_de   = de3_q;
endmodule
